// File: rtl/pwm_decoder.sv
// pwm_decoder: measures high time and period of an incoming PWM waveform in
// step ticks, emitting one result per completed period, and flags a line
// that stops toggling for TIMEOUT ticks as stuck high or stuck low.
module pwm_decoder #(
  parameter int W       = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         step,
  input  logic         pwm_in,
  output logic [W-1:0] high_time,
  output logic [W-1:0] period,
  output logic         valid,
  output logic         stuck_high,
  output logic         stuck_low
);

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] TMO = W'(TIMEOUT);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t       state, state_n;
  logic         pwm_meta, pwm_s, pwm_d;
  logic         rise, fall, any_edge, timeout;
  logic [W-1:0] hcnt, hcnt_n;
  logic [W-1:0] pcnt, pcnt_n;
  logic [W-1:0] icnt, icnt_n;
  logic [W-1:0] icnt_inc;
  logic [W-1:0] high_time_n, period_n;
  logic         valid_n, stuck_high_n, stuck_low_n;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == MAX) ? v : v + ONE;
  endfunction

  // Two-flop synchronizer plus a delay flop for edge detection; runs regardless of ena/step
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_meta <= 1'b0;
      pwm_s    <= 1'b0;
      pwm_d    <= 1'b0;
    end else begin
      pwm_meta <= pwm_in;
      pwm_s    <= pwm_meta;
      pwm_d    <= pwm_s;
    end
  end

  assign rise     = pwm_s & ~pwm_d;
  assign fall     = ~pwm_s & pwm_d;
  assign any_edge = rise | fall;
  assign icnt_inc = icnt + ONE;
  // The timeout fires only on the tick that carries icnt up to TMO, so a held line reports once
  assign timeout  = ena & ~any_edge & step & (icnt != TMO) & (icnt_inc == TMO);

  // State, counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SYNC;
      hcnt       <= '0;
      pcnt       <= '0;
      icnt       <= '0;
      high_time  <= '0;
      period     <= '0;
      valid      <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      state      <= state_n;
      hcnt       <= hcnt_n;
      pcnt       <= pcnt_n;
      icnt       <= icnt_n;
      high_time  <= high_time_n;
      period     <= period_n;
      valid      <= valid_n;
      stuck_high <= stuck_high_n;
      stuck_low  <= stuck_low_n;
    end
  end

  // Next-state and measurement logic: timeout first, otherwise edge-driven FSM with tick counting
  always_comb begin
    state_n      = state;
    hcnt_n       = hcnt;
    pcnt_n       = pcnt;
    icnt_n       = icnt;
    high_time_n  = high_time;
    period_n     = period;
    valid_n      = 1'b0;
    stuck_high_n = stuck_high;
    stuck_low_n  = stuck_low;

    if (!ena) begin
      state_n = SYNC;
      hcnt_n  = '0;
      pcnt_n  = '0;
      icnt_n  = '0;
    end else begin
      if (any_edge) begin
        icnt_n       = '0;
        stuck_high_n = 1'b0;
        stuck_low_n  = 1'b0;
      end else if (step && (icnt != TMO)) begin
        icnt_n = icnt_inc;
      end

      if (timeout) begin
        state_n      = SYNC;
        hcnt_n       = '0;
        pcnt_n       = '0;
        valid_n      = 1'b1;
        period_n     = TMO;
        high_time_n  = pwm_s ? TMO : '0;
        stuck_high_n = pwm_s;
        stuck_low_n  = ~pwm_s;
      end else begin
        case (state)
          SYNC: begin
            if (rise) begin
              state_n = HIGH;
              hcnt_n  = step ? ONE : '0;
              pcnt_n  = step ? ONE : '0;
            end
          end
          HIGH: begin
            if (step) begin
              pcnt_n = sat_inc(pcnt);
            end
            if (fall) begin
              state_n = LOW;
            end else if (step) begin
              hcnt_n = sat_inc(hcnt);
            end
          end
          LOW: begin
            if (rise) begin
              state_n     = HIGH;
              high_time_n = hcnt;
              period_n    = pcnt;
              valid_n     = 1'b1;
              hcnt_n      = step ? ONE : '0;
              pcnt_n      = step ? ONE : '0;
            end else if (step) begin
              pcnt_n = sat_inc(pcnt);
            end
          end
          default: begin
            state_n = SYNC;
            hcnt_n  = '0;
            pcnt_n  = '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: drives directed and randomized PWM waveforms into pwm_decoder
// and compares every cycle against a tick-level reference model of the
// measurement rules.
module tb_pwm_decoder;

  localparam int W       = 6;
  localparam int TIMEOUT = 40;
  localparam int MAXV    = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst, ena, step, pwm_in;
  logic [W-1:0] high_time, period;
  logic         valid, stuck_high, stuck_low;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: line history plus unbounded tick counts, saturated only when reported
  bit samp_in, samp_now, samp_prev;
  bit locked;
  int per_ticks, high_ticks, idle_ticks;
  int e_ht, e_per;
  bit e_valid, e_sh, e_sl;

  pwm_decoder #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .step       (step),
    .pwm_in     (pwm_in),
    .high_time  (high_time),
    .period     (period),
    .valid      (valid),
    .stuck_high (stuck_high),
    .stuck_low  (stuck_low)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelEdge();
    bit rise, fall, tmo;
    if (rst) begin
      samp_in = 0; samp_now = 0; samp_prev = 0;
      locked = 0; per_ticks = 0; high_ticks = 0; idle_ticks = 0;
      e_ht = 0; e_per = 0; e_valid = 0; e_sh = 0; e_sl = 0;
      return;
    end
    rise    = samp_now & ~samp_prev;
    fall    = ~samp_now & samp_prev;
    e_valid = 0;
    if (!ena) begin
      locked = 0; per_ticks = 0; high_ticks = 0; idle_ticks = 0;
    end else begin
      tmo = !(rise || fall) && step && (idle_ticks + 1 == TIMEOUT);
      if (rise || fall) begin
        idle_ticks = 0; e_sh = 0; e_sl = 0;
      end else if (step && idle_ticks < TIMEOUT) begin
        idle_ticks++;
      end
      if (tmo) begin
        e_valid = 1;
        e_per   = TIMEOUT;
        e_ht    = samp_now ? TIMEOUT : 0;
        e_sh    = samp_now;
        e_sl    = !samp_now;
        locked  = 0; per_ticks = 0; high_ticks = 0;
      end else if (rise) begin
        if (locked) begin
          e_valid = 1;
          e_ht    = sat(high_ticks);
          e_per   = sat(per_ticks);
        end
        locked     = 1;
        per_ticks  = step;
        high_ticks = step;
      end else if (locked) begin
        per_ticks += step;
        if (samp_now) high_ticks += step;
      end
    end
    samp_prev = samp_now;
    samp_now  = samp_in;
    samp_in   = pwm_in;
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic st, input logic p);
    rst = r; ena = e; step = st; pwm_in = p;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("valid",      valid,      e_valid);
    checkOutput("high_time",  high_time,  e_ht);
    checkOutput("period",     period,     e_per);
    checkOutput("stuck_high", stuck_high, e_sh);
    checkOutput("stuck_low",  stuck_low,  e_sl);
  endtask

  // step_mode 0: step every clk; 1: step on even cycle indices counted from the high phase start
  task automatic runWave(input int hi, input int lo, input int reps, input int step_mode);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi + lo; i++) begin
        applyStimulus(1'b0, 1'b1, (step_mode == 0) ? 1'b1 : ((i % 2) == 0), (i < hi));
      end
    end
  endtask

  // Main sequence: directed scenarios followed by randomized segments
  initial begin
    int vcount;
    bit lvl;
    int len, kind, smode, ena_hold, cyc;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("rst_high_time", high_time, 0);
    checkOutput("rst_period",    period,    0);
    checkOutput("rst_valid",     valid,     0);

    runWave(3, 5, 4, 0);
    checkOutput("w3_5_high_time", high_time, 3);
    checkOutput("w3_5_period",    period,    8);

    runWave(4, 12, 3, 1);
    checkOutput("w4_12_high_time", high_time, 2);
    checkOutput("w4_12_period",    period,    8);

    runWave(35, 35, 2, 0);
    checkOutput("sat_high_time", high_time, 35);
    checkOutput("sat_period",    period,    MAXV);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    vcount = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      if (valid === 1'b1) vcount++;
    end
    checkOutput("stuck_low_flag",  stuck_low, 1);
    checkOutput("stuck_low_ht",    high_time, 0);
    checkOutput("stuck_low_per",   period,    TIMEOUT);
    checkOutput("stuck_low_count", vcount,    1);
    runWave(5, 5, 1, 0);
    checkOutput("stuck_low_clear", stuck_low, 0);

    vcount = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      if (valid === 1'b1) vcount++;
    end
    checkOutput("stuck_high_flag",  stuck_high, 1);
    checkOutput("stuck_high_ht",    high_time,  TIMEOUT);
    checkOutput("stuck_high_per",   period,     TIMEOUT);
    checkOutput("stuck_high_count", vcount,     2);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("stuck_high_clear", stuck_high, 0);

    runWave(3, 5, 3, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, (i < 1));
    checkOutput("ena_off_hold_ht",  high_time, 3);
    checkOutput("ena_off_hold_per", period,    8);
    runWave(6, 6, 3, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("rst_mid_ht",  high_time, 0);
    checkOutput("rst_mid_per", period,    0);
    runWave(3, 5, 3, 0);

    lvl = 0; ena_hold = 0; cyc = 0;
    for (int seg = 0; seg < 160; seg++) begin
      lvl   = ~lvl;
      kind  = $urandom_range(0, 9);
      len   = (kind == 0) ? $urandom_range(45, 90) : (kind == 1) ? 1 : $urandom_range(2, 38);
      smode = $urandom_range(0, 2);
      for (int i = 0; i < len; i++) begin
        logic st, e, r;
        st = (smode == 0) ? 1'b1 : (smode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
        if (ena_hold > 0) begin
          ena_hold--;
          e = 1'b0;
        end else begin
          e = 1'b1;
          if ($urandom_range(0, 299) == 0) ena_hold = $urandom_range(1, 6);
        end
        r = ($urandom_range(0, 499) == 0);
        applyStimulus(r, e, st, lvl);
        cyc++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
